rx_drain_sched: RTL

RX_DRAIN_SCHED -- requirements
Module: rx_drain_sched

---
 rtl/rx_sched_pkg.sv | 25 ++
 rtl/rx_drain_sched_if.sv | 33 +++
 rtl/rr_pick.sv | 29 ++
 rtl/rx_drain_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// Shared types and constants for the RX drain scheduler: FSM state encoding,
// channel index type and ack-timeout counter width.
package rx_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam int DATA_W = 32;
    localparam int CH_W   = 2;
    // Wide enough for ACK_TMO values up to 255
    localparam int TMO_W  = 8;

    typedef logic [CH_W-1:0] ch_t;

    // Channel reached by stepping 'step' places past 'prev' on a ring of nch
    function automatic ch_t rr_next(input ch_t prev, input int step, input int nch);
        return CH_W'((int'(prev) + step) % nch);
    endfunction

endpackage

// File: rtl/rx_drain_sched_if.sv
// Bundles the per-channel Wishbone read strobes and the merged output stream.
// master = scheduler side, slave = FIFO readers / stream consumer side.
interface rx_drain_sched_if #(
    parameter int NCH = 4
);
    import rx_sched_pkg::*;

    logic [NCH-1:0]        o_wb_cyc;
    logic [NCH-1:0]        o_wb_stb;
    logic [NCH-1:0]        i_wb_stall;
    logic [NCH-1:0]        i_wb_ack;
    logic [NCH*DATA_W-1:0] i_wb_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic [DATA_W-1:0]     o_tx_data;
    logic [CH_W-1:0]       o_tx_chan;
    logic                  o_tx_last;

    modport master (
        output o_wb_cyc, o_wb_stb,
        input  i_wb_stall, i_wb_ack, i_wb_data,
        output o_tx_valid, o_tx_data, o_tx_chan, o_tx_last,
        input  i_tx_ready
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb,
        output i_wb_stall, i_wb_ack, i_wb_data,
        input  o_tx_valid, o_tx_data, o_tx_chan, o_tx_last,
        output i_tx_ready
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first requesting channel after 'prev', wrapping around.
module rr_pick
    import rx_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    input  ch_t            prev,
    output ch_t            grant,
    output logic           vld
);

    logic [3:0] req_pad;

    assign req_pad = 4'(req);

    // Walk from the farthest candidate back to prev+1 so the nearest one wins
    always_comb begin
        grant = prev;
        vld   = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (req_pad[rr_next(prev, i, NCH)]) begin
                grant = rr_next(prev, i, NCH);
                vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_drain_sched.sv
// Drains up to NCH RX FIFOs over per-channel Wishbone reads into one output
// stream, one outstanding read at a time, bursting up to BURST words per grant.
module rx_drain_sched
    import rx_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int BURST   = 4,
    parameter int COUNT_W = 3,
    parameter int ACK_TMO = 15
) (
    input  logic           i_clk,
    input  logic           rst,
    input  logic           i_enable,
    rx_drain_sched_if.master bus,
    input  logic [NCH-1:0] i_fifo_empty,
    input  logic [NCH-1:0] i_fifo_overflow,
    output logic           o_busy,
    output logic [NCH-1:0] o_ovf_sticky,
    input  logic           i_ovf_clear,
    output logic           o_tmo_sticky
);

    // Beat counter spans at least a FIFO's worth of words
    localparam int BEAT_W = (COUNT_W > $clog2(BURST + 1)) ? COUNT_W : $clog2(BURST + 1);

    state_t              state, nstate;
    ch_t                 cur_ch, last_grant, pick_ch;
    logic                pick_vld;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [3:0]          stall_pad, ack_pad, empty_pad, ch_onehot;
    logic [4*DATA_W-1:0] data_pad;
    logic                stall_g, ack_g, empty_g, tmo_hit;
    logic [DATA_W-1:0]   data_g, tx_data_r;
    logic                tx_last_r;

    assign stall_pad = 4'(bus.i_wb_stall);
    assign ack_pad   = 4'(bus.i_wb_ack);
    assign empty_pad = 4'(i_fifo_empty);
    assign data_pad  = (4*DATA_W)'(bus.i_wb_data);

    assign stall_g = stall_pad[cur_ch];
    assign ack_g   = ack_pad[cur_ch];
    assign empty_g = empty_pad[cur_ch];
    assign data_g  = data_pad[{cur_ch, 5'd0} +: DATA_W];
    assign tmo_hit = (state == S_WAIT) && !ack_g && (tmo_cnt == TMO_W'(ACK_TMO - 1));

    rr_pick #(.NCH(NCH)) u_pick (
        .req   (~i_fifo_empty),
        .prev  (last_grant),
        .grant (pick_ch),
        .vld   (pick_vld)
    );

    always_ff @(posedge i_clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (i_enable && pick_vld) nstate = S_REQ;
            S_REQ:   if (!stall_g) nstate = S_WAIT;
            S_WAIT:  if (ack_g) nstate = S_CHECK;
                     else if (tmo_hit) nstate = S_IDLE;
            S_CHECK: nstate = S_OUT;
            S_OUT:   if (bus.i_tx_ready) nstate = tx_last_r ? S_IDLE : S_REQ;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_wb_cyc   = '0;
        bus.o_wb_stb   = '0;
        bus.o_tx_valid = 1'b0;
        o_busy         = 1'b0;
        ch_onehot      = 4'b0001 << cur_ch;
        if (state != S_IDLE) begin
            o_busy       = 1'b1;
            bus.o_wb_cyc = ch_onehot[NCH-1:0];
        end
        if (state == S_REQ) bus.o_wb_stb = ch_onehot[NCH-1:0];
        if (state == S_OUT) bus.o_tx_valid = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            cur_ch       <= '0;
            last_grant   <= ch_t'(NCH - 1);
            beat_cnt     <= '0;
            tmo_cnt      <= '0;
            tx_data_r    <= '0;
            tx_last_r    <= 1'b0;
            o_ovf_sticky <= '0;
            o_tmo_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_enable && pick_vld) begin
                    cur_ch     <= pick_ch;
                    last_grant <= pick_ch;
                    beat_cnt   <= '0;
                end
                S_REQ:   tmo_cnt <= '0;
                S_WAIT:  if (ack_g) tx_data_r <= data_g;
                         else tmo_cnt <= tmo_cnt + 1'b1;
                // Enable dropping turns the beat in flight into the final one
                S_CHECK: tx_last_r <= (beat_cnt == BEAT_W'(BURST - 1)) | empty_g | !i_enable;
                S_OUT:   if (bus.i_tx_ready) beat_cnt <= beat_cnt + 1'b1;
                default: ;
            endcase
            o_ovf_sticky <= (o_ovf_sticky & ~{NCH{i_ovf_clear}}) | i_fifo_overflow;
            o_tmo_sticky <= (o_tmo_sticky & ~i_ovf_clear) | tmo_hit;
        end
    end

    assign bus.o_tx_data = tx_data_r;
    assign bus.o_tx_chan = cur_ch;
    assign bus.o_tx_last = tx_last_r;

endmodule
